// File: rtl/zap_tlb_walker_pkg.sv
// Shared definitions for the page-table walker: FSM states, descriptor type codes,
// FSR status codes and the TLB one-hot indices shared with the TLB check stage.
package zap_tlb_walker_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_L1 = 3'd1,
    S_FETCH_L2 = 3'd2,
    S_REFILL   = 3'd3,
    S_FAULT    = 3'd4
  } walk_state_t;

  // Descriptor type field, bits [1:0] of each descriptor
  localparam logic [1:0] L1_FAULT   = 2'b00;
  localparam logic [1:0] L1_PAGE    = 2'b01;
  localparam logic [1:0] L1_SECTION = 2'b10;
  localparam logic [1:0] L1_FINE    = 2'b11;
  localparam logic [1:0] L2_FAULT   = 2'b00;
  localparam logic [1:0] L2_LARGE   = 2'b01;
  localparam logic [1:0] L2_SMALL   = 2'b10;
  localparam logic [1:0] L2_TINY    = 2'b11;

  localparam logic [3:0] FSR_SECT_TRANS = 4'h5;
  localparam logic [3:0] FSR_PAGE_TRANS = 4'h7;
  localparam logic [3:0] FSR_EXT_L1     = 4'hC;
  localparam logic [3:0] FSR_EXT_L2     = 4'hE;

  localparam int unsigned TLB_SMALL   = 0;
  localparam int unsigned TLB_LARGE   = 1;
  localparam int unsigned TLB_SECTION = 2;
  localparam int unsigned TLB_FINE    = 3;

  function automatic logic [3:0] tlb_onehot(input int unsigned idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/zap_tlb_walker.sv
// Page-table walker: fetches L1 and optional L2 descriptors over a Wishbone-style
// master and either refills one TLB or reports a fault with an FSR/FAR pair.
module zap_tlb_walker
  import zap_tlb_walker_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_walk,
  input  logic [31:0] i_va,
  input  logic [31:0] i_baddr,
  input  logic        i_tlb_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [7:0]  o_fsr,
  output logic [31:0] o_far,
  output logic [3:0]  o_tlb_wen,
  output logic [21:0] o_tlb_wtag,
  output logic [31:0] o_tlb_wdata,
  output logic [3:0]  o_tlb_wdom,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_adr,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_dat,
  output walk_state_t o_dbg_state
);

  // Bus handshake: cyc/stb rise with a stable adr and stay there until the
  // first cycle that sees ack or err; err ends the transfer with no data.
  // Responses arriving while cyc is low are ignored.

  walk_state_t state_q, state_d;
  logic [31:0] va_q, va_d;
  logic [31:0] desc_q, desc_d;
  logic [3:0]  dom_q, dom_d;
  logic        fine_q, fine_d;
  logic        flush_q, flush_d;
  logic        cyc_q, cyc_d;
  logic [31:0] adr_q, adr_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [7:0]  fsr_q, fsr_d;
  logic [31:0] far_q, far_d;
  logic [3:0]  wen_q, wen_d;
  logic        busy_q;

  logic ack_v, err_v;
  logic unused_baddr;

  assign ack_v        = cyc_q & i_wb_ack & ~i_wb_err;
  assign err_v        = cyc_q & i_wb_err;
  assign unused_baddr = ^i_baddr[13:0];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      va_q    <= '0;
      desc_q  <= '0;
      dom_q   <= '0;
      fine_q  <= 1'b0;
      flush_q <= 1'b0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      fsr_q   <= '0;
      far_q   <= '0;
      wen_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      desc_q  <= desc_d;
      dom_q   <= dom_d;
      fine_q  <= fine_d;
      flush_q <= flush_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      fsr_q   <= fsr_d;
      far_q   <= far_d;
      wen_q   <= wen_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (i_walk) state_d = S_FETCH_L1;
      S_FETCH_L1: begin
        if (err_v) state_d = S_FAULT;
        else if (ack_v) begin
          case (i_wb_dat[1:0])
            L1_SECTION:       state_d = S_REFILL;
            L1_PAGE, L1_FINE: state_d = S_FETCH_L2;
            default:          state_d = S_FAULT;
          endcase
        end
      end
      S_FETCH_L2: begin
        if (err_v) state_d = S_FAULT;
        else if (ack_v) begin
          case (i_wb_dat[1:0])
            L2_LARGE, L2_SMALL: state_d = S_REFILL;
            L2_TINY:            state_d = fine_q ? S_REFILL : S_FAULT;
            default:            state_d = S_FAULT;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Computes the registered outputs and datapath for the cycle after each edge.
  always_comb begin
    va_d    = va_q;
    desc_d  = desc_q;
    dom_d   = dom_q;
    fine_d  = fine_q;
    flush_d = flush_q | i_tlb_flush;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    fsr_d   = '0;
    far_d   = '0;
    wen_d   = '0;
    case (state_q)
      S_IDLE: begin
        flush_d = 1'b0;
        if (i_walk) begin
          va_d    = i_va;
          desc_d  = '0;
          dom_d   = '0;
          fine_d  = 1'b0;
          flush_d = i_tlb_flush;
          cyc_d   = 1'b1;
          adr_d   = {i_baddr[31:14], i_va[31:20], 2'b00};
        end
      end
      S_FETCH_L1: begin
        if (err_v) begin
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          fault_d = 1'b1;
          fsr_d   = {4'h0, FSR_EXT_L1};
          far_d   = va_q;
        end else if (ack_v) begin
          cyc_d = 1'b0;
          dom_d = i_wb_dat[8:5];
          case (i_wb_dat[1:0])
            L1_SECTION: begin
              desc_d = i_wb_dat;
              done_d = 1'b1;
              wen_d  = flush_d ? 4'b0000 : tlb_onehot(TLB_SECTION);
            end
            L1_PAGE: adr_d = {i_wb_dat[31:10], va_q[19:12], 2'b00};
            L1_FINE: begin
              adr_d  = {i_wb_dat[31:12], va_q[19:10], 2'b00};
              fine_d = 1'b1;
            end
            default: begin
              dom_d   = 4'h0;
              done_d  = 1'b1;
              fault_d = 1'b1;
              fsr_d   = {4'h0, FSR_SECT_TRANS};
              far_d   = va_q;
            end
          endcase
        end
      end
      S_FETCH_L2: begin
        // First cycle here is the mandatory idle gap between the two fetches
        if (!cyc_q) begin
          cyc_d = 1'b1;
        end else if (err_v) begin
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          fault_d = 1'b1;
          fsr_d   = {dom_q, FSR_EXT_L2};
          far_d   = va_q;
        end else if (ack_v) begin
          cyc_d  = 1'b0;
          done_d = 1'b1;
          if (state_d == S_REFILL) begin
            desc_d = i_wb_dat;
            case (i_wb_dat[1:0])
              L2_LARGE: wen_d = tlb_onehot(TLB_LARGE);
              L2_SMALL: wen_d = tlb_onehot(TLB_SMALL);
              default:  wen_d = tlb_onehot(TLB_FINE);
            endcase
            if (flush_d) wen_d = 4'b0000;
          end else begin
            fault_d = 1'b1;
            fsr_d   = {dom_q, FSR_PAGE_TRANS};
            far_d   = va_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_fault     = fault_q;
  assign o_fsr       = fsr_q;
  assign o_far       = far_q;
  assign o_tlb_wen   = wen_q;
  assign o_tlb_wtag  = va_q[31:10];
  assign o_tlb_wdata = desc_q;
  assign o_tlb_wdom  = dom_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = cyc_q;
  assign o_wb_adr    = adr_q;
  assign o_dbg_state = state_q;

endmodule
